// File: rtl/uart_pkg.sv
// Shared UART definitions: default baud settings, XOR key and the
// state encodings used by the BRAM dump transmitter.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEF  = 50_000_000;
    localparam int unsigned BAUD_RATE_DEF = 115_200;
    localparam logic [7:0]  XOR_KEY_DEF   = 8'hAA;

    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

    typedef enum logic [2:0] {
        D_IDLE,
        D_ZERO,
        D_FETCH,
        D_LOAD,
        D_SEND,
        D_NEXT
    } dump_state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_DATA,
        T_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit.
// tx is registered, so the line lags the internal state by one cycle.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    assign bit_end = (cnt_q == LAST);
    assign tx      = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_ready also flags the final stop-bit cycle so the caller can
    // count the frame without losing a cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        tx_ready = 1'b0;
        unique case (state_q)
            T_IDLE: begin
                tx_ready = 1'b1;
                cnt_d    = '0;
                if (tx_valid) begin
                    shift_d = tx_data;
                    bit_d   = 3'd0;
                    state_d = T_START;
                end
            end
            T_START: begin
                tx_d = 1'b0;
                if (bit_end) state_d = T_DATA;
            end
            T_DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = T_STOP;
                end
            end
            T_STOP: begin
                if (bit_end) begin
                    tx_ready = 1'b1;
                    state_d  = T_IDLE;
                end
            end
            default: state_d = T_IDLE;
        endcase
    end

endmodule

// File: rtl/bram_dump_uart_tx.sv
// Reads len bytes from a BRAM port and sends each as an 8N1 frame,
// optionally XOR-decrypting; busy/done drive the status LEDs.
module bram_dump_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
    parameter int unsigned BAUD_RATE    = BAUD_RATE_DEF,
    parameter int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE),
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter logic [7:0]  XOR_KEY      = XOR_KEY_DEF,
    parameter bit          DECRYPT      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   byte_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [7:0]            mem_rd_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   sent_count
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [7:0] KEY = DECRYPT ? XOR_KEY : 8'h00;

    dump_state_e           state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   sent_q, sent_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH:0]   len_clamp;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [7:0]            tx_data;

    assign len_clamp  = (byte_count > DEPTH) ? DEPTH : byte_count;
    assign tx_data    = mem_rd_data ^ KEY;
    assign mem_addr   = addr_q;
    assign mem_rd_en  = rd_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sent_count = sent_q;

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= D_IDLE;
            len_q   <= '0;
            sent_q  <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            addr_q  <= addr_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // busy stays high through the done cycle so a start there is ignored.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sent_d   = sent_q;
        addr_d   = addr_q;
        rd_en_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tx_valid = 1'b0;
        unique case (state_q)
            D_IDLE: begin
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start && !busy_q) begin
                    len_d  = len_clamp;
                    sent_d = '0;
                    addr_d = '0;
                    busy_d = 1'b1;
                    if (len_clamp != '0) begin
                        rd_en_d = 1'b1;
                        state_d = D_FETCH;
                    end else begin
                        state_d = D_ZERO;
                    end
                end
            end
            D_ZERO: begin
                done_d  = 1'b1;
                state_d = D_IDLE;
            end
            D_FETCH: state_d = D_LOAD;
            D_LOAD: begin
                tx_valid = 1'b1;
                state_d  = D_SEND;
            end
            D_SEND: begin
                if (tx_ready) begin
                    sent_d  = sent_q + (ADDR_WIDTH + 1)'(1);
                    state_d = D_NEXT;
                end
            end
            D_NEXT: begin
                if (sent_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = D_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    rd_en_d = 1'b1;
                    state_d = D_FETCH;
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bram_dump_uart_tx.sv
// Bench: raw and decrypting instances, a BRAM model and a UART frame
// decoder, compared against the stored bytes with plain arithmetic.
module tb_bram_dump_uart_tx;

    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int PERIOD = 103;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start [2];
    logic [AW:0]   byte_count [2];
    logic [AW-1:0] mem_addr [2];
    logic          mem_rd_en [2];
    logic [7:0]    mem_rd_data [2];
    logic          tx [2];
    logic          busy [2];
    logic          done [2];
    logic [AW:0]   sent_count [2];

    logic [7:0] mem [2][DEPTH];
    logic [7:0] rxq [2][$];
    logic       stopq [2][$];
    int         fallq [2][$];
    int         addrq [2][$];
    int         done_cnt [2] = '{0, 0};
    logic       rx_on [2] = '{1'b0, 1'b0};
    int         rx_t [2] = '{0, 0};
    int         rx_fall [2] = '{0, 0};
    logic [7:0] rx_b [2];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int qb, ab, db;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bram_dump_uart_tx #(
            .CLK_FREQ  (1000),
            .BAUD_RATE (100),
            .ADDR_WIDTH(AW),
            .XOR_KEY   (8'hAA),
            .DECRYPT   (g == 1)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[g]),
            .byte_count (byte_count[g]),
            .mem_addr   (mem_addr[g]),
            .mem_rd_en  (mem_rd_en[g]),
            .mem_rd_data(mem_rd_data[g]),
            .tx         (tx[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .sent_count (sent_count[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++)
            if (mem_rd_en[g] === 1'b1) mem_rd_data[g] <= mem[g][mem_addr[g]];
    end

    // Reads, done pulses and a mid-bit sampling UART receiver per instance.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (mem_rd_en[g] === 1'b1) addrq[g].push_back(int'(mem_addr[g]));
            if (done[g] === 1'b1) done_cnt[g] <= done_cnt[g] + 1;
            if (!rx_on[g]) begin
                if (tx[g] === 1'b0) begin
                    rx_on[g]   <= 1'b1;
                    rx_t[g]    <= 0;
                    rx_fall[g] <= cyc;
                end
            end else begin
                rx_t[g] <= rx_t[g] + 1;
                if (rx_t[g] + 1 >= 15 && rx_t[g] + 1 <= 85 && (rx_t[g] + 1 - 15) % 10 == 0)
                    rx_b[g][(rx_t[g] + 1 - 15) / 10] <= tx[g];
                if (rx_t[g] + 1 == 95) begin
                    rxq[g].push_back(rx_b[g]);
                    stopq[g].push_back(tx[g]);
                    fallq[g].push_back(rx_fall[g]);
                    rx_on[g] <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int g);
        qb = rxq[g].size();
        ab = addrq[g].size();
        db = done_cnt[g];
    endtask

    task automatic kick(input int g, input int n);
        tick();
        start[g] = 1'b1;
        byte_count[g] = (AW + 1)'(n);
        tick();
        start[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        for (int i = 0; i < 4000 && busy[g] !== 1'b0; i++) tick();
        chk($sformatf("busy_clear%0d", g), busy[g], 0);
        repeat (2) tick();
    endtask

    task automatic fill(input int g);
        for (int a = 0; a < DEPTH; a++) mem[g][a] = 8'($urandom);
    endtask

    function automatic logic [7:0] exp_byte(input int g, input int a);
        return mem[g][a] ^ ((g == 1) ? 8'hAA : 8'h00);
    endfunction

    task automatic check_dump(input int g, input int n);
        int len;
        len = (n > DEPTH) ? DEPTH : n;
        chk($sformatf("frames%0d_n%0d", g, n), rxq[g].size() - qb, len);
        for (int i = 0; i < len && qb + i < rxq[g].size(); i++) begin
            chk($sformatf("data%0d_%0d", g, i), rxq[g][qb + i], exp_byte(g, i));
            chk($sformatf("stop%0d_%0d", g, i), stopq[g][qb + i], 1);
            if (i > 0)
                chk($sformatf("gap%0d_%0d", g, i),
                    fallq[g][qb + i] - fallq[g][qb + i - 1], PERIOD);
        end
        chk($sformatf("reads%0d_n%0d", g, n), addrq[g].size() - ab, len);
        for (int i = 0; i < len && ab + i < addrq[g].size(); i++)
            chk($sformatf("addr%0d_%0d", g, i), addrq[g][ab + i], i);
        chk($sformatf("done_once%0d", g), done_cnt[g] - db, 1);
        chk($sformatf("sent%0d", g), sent_count[g], len);
        chk($sformatf("last_addr%0d", g), mem_addr[g], (len > 0) ? len - 1 : 0);
    endtask

    initial begin
        int g;
        int n;
        start = '{1'b0, 1'b0};
        byte_count = '{'0, '0};
        fill(0);
        fill(1);
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tx%0d", i), tx[i], 1);
            chk($sformatf("rst_busy%0d", i), busy[i], 0);
            chk($sformatf("rst_done%0d", i), done[i], 0);
            chk($sformatf("rst_rd%0d", i), mem_rd_en[i], 0);
            chk($sformatf("rst_addr%0d", i), mem_addr[i], 0);
            chk($sformatf("rst_sent%0d", i), sent_count[i], 0);
        end
        rst = 1'b0;
        tick();

        mem[0][0] = 8'h55;
        snap(0);
        kick(0, 1);
        chk("a_busy", busy[0], 1);
        chk("a_rd_k1", mem_rd_en[0], 1);
        chk("a_addr_k1", mem_addr[0], 0);
        tick();
        chk("a_rd_k2", mem_rd_en[0], 0);
        chk("a_tx_k2", tx[0], 1);
        tick();
        chk("a_tx_k3", tx[0], 1);
        tick();
        chk("a_tx_start", tx[0], 0);
        wait_idle(0);
        check_dump(0, 1);

        mem[1][0] = 8'hAA;
        mem[1][1] = 8'h00;
        mem[1][2] = 8'hFF;
        snap(1);
        kick(1, 3);
        wait_idle(1);
        check_dump(1, 3);
        if (rxq[1].size() >= qb + 3) begin
            chk("b_plain0", rxq[1][qb], 8'h00);
            chk("b_plain1", rxq[1][qb + 1], 8'hAA);
            chk("b_plain2", rxq[1][qb + 2], 8'h55);
        end

        snap(0);
        kick(0, 0);
        chk("z_busy", busy[0], 1);
        chk("z_done_early", done[0], 0);
        tick();
        chk("z_done", done[0], 1);
        chk("z_tx", tx[0], 1);
        tick();
        chk("z_done_off", done[0], 0);
        chk("z_busy_off", busy[0], 0);
        check_dump(0, 0);

        fill(0);
        snap(0);
        kick(0, 20);
        wait_idle(0);
        check_dump(0, 20);

        fill(1);
        snap(1);
        kick(1, 4);
        repeat (130) tick();
        start[1] = 1'b1;
        byte_count[1] = 5'd2;
        tick();
        start[1] = 1'b0;
        chk("e_busy", busy[1], 1);
        wait_idle(1);
        check_dump(1, 4);

        snap(0);
        kick(0, 4);
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("r_tx", tx[0], 1);
        chk("r_busy", busy[0], 0);
        chk("r_sent", sent_count[0], 0);
        chk("r_rd", mem_rd_en[0], 0);
        repeat (100) tick();
        chk("r_no_done", done_cnt[0] - db, 0);
        snap(0);
        kick(0, 3);
        chk("r_addr0", mem_addr[0], 0);
        wait_idle(0);
        check_dump(0, 3);

        for (int it = 0; it < 4; it++) begin
            g = int'($urandom_range(0, 1));
            n = int'($urandom_range(0, 31));
            fill(g);
            snap(g);
            kick(g, n);
            wait_idle(g);
            check_dump(g, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
